// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// with a one-entry registered response buffer tagged by requester ID.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             req1_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_err
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    logic             prio_reg, prio_next;
    logic             resp_valid_reg, resp_valid_next;
    logic             resp_id_reg, resp_id_next;
    logic [WIDTH-1:0] resp_result_reg, resp_result_next;
    logic             resp_zero_reg, resp_zero_next;
    logic             resp_err_reg, resp_err_next;

    logic [1:0]       valid_vec, grant, ready_vec;
    logic             slot_free, accept, sel;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [2:0]       alu_op;
    logic             alu_illegal;

    assign valid_vec = {req1_valid, req0_valid};
    assign slot_free = !resp_valid_reg || resp_ready;

    always_comb begin
        grant = 2'b00;
        if (&valid_vec) begin
            grant[prio_reg] = 1'b1;
        end else begin
            grant = valid_vec;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready_vec[gi] = grant[gi] && slot_free;
    end

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign accept     = |ready_vec;

    // Idle cycles fall through to requester 0 so the mux never needs a third leg.
    assign sel    = grant[1];
    assign alu_a  = sel ? req1_a  : req0_a;
    assign alu_b  = sel ? req1_b  : req0_b;
    assign alu_op = sel ? req1_op : req0_op;

    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_illegal = 1'b1;
        endcase
    end

    // Illegal ops leave alu_result at zero, so the zero flag reads 1 for them too.
    always_comb begin
        prio_next        = prio_reg;
        resp_valid_next  = resp_valid_reg;
        resp_id_next     = resp_id_reg;
        resp_result_next = resp_result_reg;
        resp_zero_next   = resp_zero_reg;
        resp_err_next    = resp_err_reg;
        if (accept) begin
            resp_valid_next  = 1'b1;
            resp_id_next     = sel;
            resp_result_next = alu_result;
            resp_zero_next   = (alu_result == '0);
            resp_err_next    = alu_illegal;
            prio_next        = ~sel;
        end else if (resp_ready) begin
            resp_valid_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg        <= 1'b0;
            resp_valid_reg  <= 1'b0;
            resp_id_reg     <= 1'b0;
            resp_result_reg <= '0;
            resp_zero_reg   <= 1'b0;
            resp_err_reg    <= 1'b0;
        end else begin
            prio_reg        <= prio_next;
            resp_valid_reg  <= resp_valid_next;
            resp_id_reg     <= resp_id_next;
            resp_result_reg <= resp_result_next;
            resp_zero_reg   <= resp_zero_next;
            resp_err_reg    <= resp_err_next;
        end
    end

    assign resp_valid  = resp_valid_reg;
    assign resp_id     = resp_id_reg;
    assign resp_result = resp_result_reg;
    assign resp_zero   = resp_zero_reg;
    assign resp_err    = resp_err_reg;

endmodule
